// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Imported by the interfaces, the byte-lane helper and the top.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        RESP
    } lsu_state_e;

    typedef logic [1:0] lane_t;

    localparam int WORD_SHIFT = 2;

endpackage

// File: rtl/lsu_if.sv
// Handshake bundles for the load/store unit: the core request/response side
// and the word-wide data memory port.
interface lsu_req_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic        req_byte;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_store, req_byte, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_store, req_byte, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

interface lsu_mem_if;

    logic [31:0] mem_a;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    modport master (
        output mem_a, mem_we, mem_wd,
        input  mem_rd
    );

    modport slave (
        input  mem_a, mem_we, mem_wd,
        output mem_rd
    );

endinterface

// File: rtl/lsu_byte_lane.sv
// Little-endian byte lane extract (zero-extended) and merge for LDRB/STRB.
import lsu_pkg::*;

module lsu_byte_lane (
    input  logic [31:0] word_i,
    input  lane_t       lane_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] ext_o,
    output logic [31:0] merged_o
);

    always_comb begin
        ext_o    = '0;
        merged_o = word_i;
        unique case (lane_i)
            2'd0: begin
                ext_o[7:0]     = word_i[7:0];
                merged_o[7:0]  = byte_i;
            end
            2'd1: begin
                ext_o[7:0]     = word_i[15:8];
                merged_o[15:8] = byte_i;
            end
            2'd2: begin
                ext_o[7:0]      = word_i[23:16];
                merged_o[23:16] = byte_i;
            end
            2'd3: begin
                ext_o[7:0]      = word_i[31:24];
                merged_o[31:24] = byte_i;
            end
            default: begin
                ext_o    = '0;
                merged_o = word_i;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data memory initiator: word loads/stores, zero-extended byte loads and
// read-modify-write byte stores over a whole-word write enable.
import lsu_pkg::*;

module load_store_unit #(
    parameter int MEM_WORDS = 256
) (
    input  logic       clk,
    input  logic       rst,
    lsu_req_if.slave   req,
    lsu_mem_if.master  mem
);

    lsu_state_e  state_q;
    lane_t       lane_q;
    logic        store_q;
    logic        byte_q;
    logic [7:0]  wdata_q;

    logic        ready_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rdata_q;
    logic [31:0] a_q;
    logic        we_q;
    logic [31:0] wd_q;

    logic [31:0] idx_d;
    logic        err_d;
    logic [31:0] ext_w;
    logic [31:0] merged_w;

    assign idx_d = req.req_addr >> WORD_SHIFT;
    assign err_d = (!req.req_byte && (req.req_addr[1:0] != 2'b00))
                 || (idx_d >= 32'(MEM_WORDS));

    lsu_byte_lane u_lane (
        .word_i   (mem.mem_rd),
        .lane_i   (lane_q),
        .byte_i   (wdata_q),
        .ext_o    (ext_w),
        .merged_o (merged_w)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lane_q      <= '0;
            store_q     <= 1'b0;
            byte_q      <= 1'b0;
            wdata_q     <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rdata_q     <= '0;
            a_q         <= '0;
            we_q        <= 1'b0;
            wd_q        <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req.req_valid) begin
                        a_q     <= idx_d;
                        lane_q  <= lane_t'(req.req_addr[1:0]);
                        store_q <= req.req_store;
                        byte_q  <= req.req_byte;
                        wdata_q <= req.req_wdata[7:0];
                        ready_q <= 1'b0;
                        if (err_d) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rdata_q     <= '0;
                        end else if (req.req_store && !req.req_byte) begin
                            state_q <= WR;
                            we_q    <= 1'b1;
                            wd_q    <= req.req_wdata;
                        end else begin
                            state_q <= RD;
                        end
                    end
                end
                RD: begin
                    // mem_rd is captured here, both for loads and for the
                    // read half of a byte store
                    if (store_q) begin
                        state_q <= WR;
                        we_q    <= 1'b1;
                        wd_q    <= merged_w;
                    end else begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rdata_q     <= byte_q ? ext_w : mem.mem_rd;
                    end
                end
                WR: begin
                    state_q     <= RESP;
                    we_q        <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rdata_q     <= '0;
                end
                RESP: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                    ready_q     <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req.req_ready = ready_q;
    assign req.rsp_valid = rsp_valid_q;
    assign req.rsp_err   = rsp_err_q;
    assign req.rsp_rdata = rdata_q;
    assign mem.mem_a     = a_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_wd    = wd_q;

endmodule
